// File: rtl/serial_init_port.sv
// serial_init_port -- initiator-side port of the serial bus.
//
// Accepts a parallel address/data request from an initiator core, requests the
// bus from the arbiter and, once granted, shifts the address (and write data)
// out LSB first. Reads are deserialised from the target back into a byte.
//
// Optional feature: define SERIAL_INIT_PORT_TIMEOUT_EN to bound the read wait
// to READ_TIMEOUT cycles; on expiry init_data_in returns all ones.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   init_req                  core requests a transaction
//   init_addr_out(_valid)     address from core and its capture strobe
//   init_data_out(_valid)     write data from core and its capture strobe
//   init_rw                   1=write, 0=read (latched into bus_init_rw)
//   init_ready                core ready, passed through as bus_init_ready
//   arbiter_req/arbiter_grant bus request / grant handshake
//   bus_data_out(_valid)      serial address/data toward the bus
//   bus_mode                  1=address phase, 0=data phase
//   bus_data_in(_valid)       serial read data from the target
//   init_data_in(_valid)      assembled read byte, one-cycle valid pulse
//   target_ack/target_split   passed through as init_ack/init_split_ack
//   init_grant                arbiter_grant passed through
module serial_init_port #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  input  logic                  arbiter_grant,
  input  logic [DATA_WIDTH-1:0] init_data_out,
  input  logic                  init_data_out_valid,
  input  logic [ADDR_WIDTH-1:0] init_addr_out,
  input  logic                  init_addr_out_valid,
  input  logic                  init_rw,
  input  logic                  init_ready,
  input  logic                  target_split,
  input  logic                  target_ack,
  input  logic                  bus_data_in,
  input  logic                  bus_data_in_valid,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  output logic                  arbiter_req,
  output logic                  init_grant,
  output logic [DATA_WIDTH-1:0] init_data_in,
  output logic                  init_data_in_valid,
  output logic                  init_ack,
  output logic                  init_split_ack,
  output logic                  bus_init_ready,
  output logic                  bus_init_rw
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_WDATA,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Address/data are held in shift registers that are consumed as bits go out,
  // so each transaction needs a freshly captured address.
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic                  addr_captured;
  logic [CNT_W-1:0]      bit_cnt;

  logic capture_en;
  logic shift_addr;
  logic shift_data;
  logic shift_rd;
  logic rd_full;
  logic rd_timeout;

  assign init_grant     = arbiter_grant;
  assign init_ack       = target_ack;
  assign init_split_ack = target_split;
  assign bus_init_ready = init_ready;

  assign shift_rd = (state == S_RD_WAIT) && bus_data_in_valid;
  assign rd_full  = shift_rd && (bit_cnt == DATA_LAST);

`ifdef SERIAL_INIT_PORT_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(READ_TIMEOUT + 1);
  logic [TMR_W-1:0] rd_timer;

  // Counts cycles spent in the read wait; zero on the first wait cycle.
  always_ff @(posedge clk) begin
    if (rst || (state != S_RD_WAIT)) begin
      rd_timer <= '0;
    end else begin
      rd_timer <= rd_timer + 1'b1;
    end
  end

  assign rd_timeout = (state == S_RD_WAIT) && !rd_full &&
                      (rd_timer == TMR_W'(READ_TIMEOUT - 1));
`else
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    arbiter_req        = 1'b0;
    bus_mode           = 1'b0;
    bus_data_out       = 1'b0;
    bus_data_out_valid = 1'b0;
    capture_en         = 1'b0;
    shift_addr         = 1'b0;
    shift_data         = 1'b0;
    unique case (state)
      S_IDLE: begin
        capture_en = 1'b1;
        if (init_req && addr_captured) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        capture_en  = 1'b1;
        arbiter_req = 1'b1;
        if (arbiter_grant) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        arbiter_req = 1'b1;
        bus_mode    = 1'b1;
        // Without grant the bit is held back and resent once regranted.
        if (arbiter_grant) begin
          bus_data_out_valid = 1'b1;
          bus_data_out       = addr_sh[0];
          shift_addr         = 1'b1;
          if (bit_cnt == ADDR_LAST) begin
            state_nxt = bus_init_rw ? S_WDATA : S_RD_WAIT;
          end
        end
      end
      S_WDATA: begin
        arbiter_req = 1'b1;
        if (arbiter_grant) begin
          bus_data_out_valid = 1'b1;
          bus_data_out       = data_sh[0];
          shift_data         = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_RD_WAIT: begin
        arbiter_req = 1'b1;
        if (rd_full || rd_timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!init_req) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_sh            <= '0;
      data_sh            <= '0;
      rd_sh              <= '0;
      addr_captured      <= 1'b0;
      bit_cnt            <= '0;
      bus_init_rw        <= 1'b0;
      init_data_in       <= '0;
      init_data_in_valid <= 1'b0;
    end else begin
      init_data_in_valid <= 1'b0;

      if (capture_en && init_addr_out_valid) begin
        addr_sh       <= init_addr_out;
        addr_captured <= 1'b1;
      end
      if (capture_en && init_data_out_valid) begin
        data_sh <= init_data_out;
      end

      if ((state == S_IDLE) && (state_nxt == S_REQ)) begin
        bus_init_rw <= init_rw;
      end
      if ((state == S_DONE) && (state_nxt == S_IDLE)) begin
        addr_captured <= 1'b0;
      end

      if (shift_addr) begin
        addr_sh <= addr_sh >> 1;
      end
      if (shift_data) begin
        data_sh <= data_sh >> 1;
      end
      if (shift_rd) begin
        rd_sh <= {bus_data_in, rd_sh[DATA_WIDTH-1:1]};
      end

      if (rd_full) begin
        init_data_in       <= {bus_data_in, rd_sh[DATA_WIDTH-1:1]};
        init_data_in_valid <= 1'b1;
      end else if (rd_timeout) begin
        init_data_in       <= '1;
        init_data_in_valid <= 1'b1;
      end

      if (state != state_nxt) begin
        bit_cnt <= '0;
      end else if (shift_addr || shift_data || shift_rd) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_init_port.sv
// Testbench for serial_init_port: directed and randomized transactions checked
// against an expected serial stream built from the address/data values.
module tb_serial_init_port;

`ifdef SERIAL_INIT_PORT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        arbiter_grant;
  logic [7:0]  init_data_out;
  logic        init_data_out_valid;
  logic [15:0] init_addr_out;
  logic        init_addr_out_valid;
  logic        init_rw;
  logic        init_ready;
  logic        target_split;
  logic        target_ack;
  logic        bus_data_in;
  logic        bus_data_in_valid;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        arbiter_req;
  logic        init_grant;
  logic [7:0]  init_data_in;
  logic        init_data_in_valid;
  logic        init_ack;
  logic        init_split_ack;
  logic        bus_init_ready;
  logic        bus_init_rw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_init_port #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .READ_TIMEOUT(64)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .init_req           (init_req),
    .arbiter_grant      (arbiter_grant),
    .init_data_out      (init_data_out),
    .init_data_out_valid(init_data_out_valid),
    .init_addr_out      (init_addr_out),
    .init_addr_out_valid(init_addr_out_valid),
    .init_rw            (init_rw),
    .init_ready         (init_ready),
    .target_split       (target_split),
    .target_ack         (target_ack),
    .bus_data_in        (bus_data_in),
    .bus_data_in_valid  (bus_data_in_valid),
    .bus_data_out       (bus_data_out),
    .bus_data_out_valid (bus_data_out_valid),
    .bus_mode           (bus_mode),
    .arbiter_req        (arbiter_req),
    .init_grant         (init_grant),
    .init_data_in       (init_data_in),
    .init_data_in_valid (init_data_in_valid),
    .init_ack           (init_ack),
    .init_split_ack     (init_split_ack),
    .bus_init_ready     (bus_init_ready),
    .bus_init_rw        (bus_init_rw)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One transaction: present address/data, raise init_req, then each cycle
  // drive grant/read bits and collect every valid serial bit with its mode.
  task automatic run_txn(input logic [15:0] a, input logic [7:0] d, input logic rw,
                         input logic [7:0] rb, input int drop_at, input int rst_at,
                         input bit rand_drops, input bit respond, input int budget);
    logic [31:0] got_d, got_m, exp_d, exp_m;
    logic [7:0]  rd_val;
    int got_n, exp_n, first_v, last_v, pulses, pulse_cyc, last_addr_cyc, rd_idx, hold;
    bit seen_req, finished, dropped, forced_low, aborted, expect_hang;
    got_d = '0; got_m = '0; exp_d = '0; exp_m = '0; rd_val = '0;
    got_n = 0; first_v = -1; last_v = -1; pulses = 0; pulse_cyc = -1;
    last_addr_cyc = -1; rd_idx = 0; hold = 0;
    seen_req = 0; finished = 0; dropped = 0; aborted = 0;

    @(posedge clk); #1;
    init_addr_out = a; init_addr_out_valid = 1'b1;
    init_data_out = d; init_data_out_valid = 1'b1;
    init_rw = rw;
    @(posedge clk); #1;
    init_addr_out_valid = 1'b0; init_data_out_valid = 1'b0;
    init_req = 1'b1;

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (drop_at >= 0 && !dropped && got_n == drop_at) begin
        hold = 3; dropped = 1;
      end
      forced_low = 0;
      if (hold > 0) begin
        arbiter_grant = 1'b0; hold--; forced_low = 1;
      end else begin
        arbiter_grant = rand_drops ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      target_split      = rand_drops ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_data_in       = 1'($urandom_range(0, 1));
      bus_data_in_valid = 1'b0;
      if (!rw && respond && got_n >= 16 && rd_idx < 8 && $urandom_range(0, 2) != 0) begin
        bus_data_in = rb[rd_idx]; bus_data_in_valid = 1'b1; rd_idx++;
      end
      rst = (rst_at >= 0 && got_n == rst_at);

      @(negedge clk);
      if (arbiter_req) seen_req = 1;
      if (seen_req) init_rw = ~rw;
      if (forced_low) chk("drop_valid", 32'(bus_data_out_valid), 32'd0);
      if (bus_data_out_valid && got_n < 32) begin
        got_d[got_n] = bus_data_out;
        got_m[got_n] = bus_mode;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (got_n == 15) last_addr_cyc = cyc;
        got_n++;
      end
      if (init_data_in_valid) begin
        pulses++; rd_val = init_data_in; pulse_cyc = cyc;
      end
      if (rst) begin
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus_data_out_valid), 32'd0);
        chk("rst_req", 32'(arbiter_req), 32'd0);
        chk("rst_mode", 32'(bus_mode), 32'd0);
        chk("rst_rdv", 32'(init_data_in_valid), 32'd0);
        chk("rst_rw", 32'(bus_init_rw), 32'd0);
        aborted = 1; finished = 1;
      end else if (seen_req && !arbiter_req) begin
        finished = 1;
      end
      @(posedge clk); #1;
    end

    if (aborted) begin
      init_req = 1'b0;
      return;
    end

    expect_hang = !rw && !respond && !TMO_EN;
    if (expect_hang) begin
      chk("hang_req", 32'(arbiter_req), 32'd1);
      chk("hang_pulse", 32'(pulses), 32'd0);
      rst = 1'b1; init_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    chk("finished", 32'(finished), 32'd1);
    exp_n = rw ? 24 : 16;
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = a[i]; exp_m[i] = 1'b1;
    end
    if (rw) begin
      for (int i = 0; i < 8; i++) begin
        exp_d[16 + i] = d[i]; exp_m[16 + i] = 1'b0;
      end
    end
    chk("stream_len", 32'(got_n), 32'(exp_n));
    chk("stream_data", got_d, exp_d);
    chk("stream_mode", got_m, exp_m);
    chk("rw_latch", 32'(bus_init_rw), 32'(rw));
    if (drop_at < 0 && !rand_drops) chk("contiguous", 32'(last_v - first_v), 32'(exp_n - 1));
    if (!rw) chk("rd_data", 32'(rd_val), respond ? 32'(rb) : 32'hFF);
    if (!rw && !respond) chk("tmo_latency", 32'(pulse_cyc - last_addr_cyc), 32'd65);

    // init_req held after completion must not start another transaction.
    arbiter_grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_req", 32'(arbiter_req), 32'd0);
      chk("hold_valid", 32'(bus_data_out_valid), 32'd0);
      if (init_data_in_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("pulses", 32'(pulses), rw ? 32'd0 : 32'd1);
    init_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd, rb;
    logic        rrw;
    logic        g, ak, sp, rdy;
    rst = 1'b1; init_req = 1'b0; arbiter_grant = 1'b0;
    init_data_out = '0; init_data_out_valid = 1'b0;
    init_addr_out = '0; init_addr_out_valid = 1'b0;
    init_rw = 1'b0; init_ready = 1'b0; target_split = 1'b0; target_ack = 1'b0;
    bus_data_in = 1'b0; bus_data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req", 32'(arbiter_req), 32'd0);
    chk("reset_valid", 32'(bus_data_out_valid), 32'd0);
    chk("reset_mode", 32'(bus_mode), 32'd0);
    chk("reset_rdata", 32'(init_data_in), 32'd0);
    chk("reset_rdv", 32'(init_data_in_valid), 32'd0);
    chk("reset_rw", 32'(bus_init_rw), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      g = 1'($urandom_range(0, 1)); ak = 1'($urandom_range(0, 1));
      sp = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
      arbiter_grant = g; target_ack = ak; target_split = sp; init_ready = rdy;
      #1;
      chk("pass_grant", 32'(init_grant), 32'(g));
      chk("pass_ack", 32'(init_ack), 32'(ak));
      chk("pass_split", 32'(init_split_ack), 32'(sp));
      chk("pass_ready", 32'(bus_init_ready), 32'(rdy));
    end
    arbiter_grant = 1'b0; target_ack = 1'b0; target_split = 1'b0; init_ready = 1'b1;

    run_txn(16'h800A, 8'h5C, 1'b1, 8'h00, -1, -1, 1'b0, 1'b1, 200);
    run_txn(16'h8F44, 8'h00, 1'b0, 8'hA7, -1, -1, 1'b0, 1'b1, 200);
    run_txn(16'h3C5A, 8'h96, 1'b1, 8'h00, 5, -1, 1'b0, 1'b1, 200);
    run_txn(16'h1234, 8'hE1, 1'b1, 8'h00, -1, 19, 1'b0, 1'b1, 200);

    // No captured address after reset: init_req alone must not request the bus.
    init_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_addr_req", 32'(arbiter_req), 32'd0);
      @(posedge clk); #1;
    end
    init_req = 1'b0;
    @(posedge clk); #1;

    run_txn(16'hBEEF, 8'h00, 1'b0, 8'h00, -1, -1, 1'b0, 1'b0, 120);

    for (int t = 0; t < 12; t++) begin
      ra = 16'($urandom); rd = 8'($urandom); rb = 8'($urandom);
      rrw = 1'($urandom_range(0, 1));
      run_txn(ra, rd, rrw, rb, -1, -1, 1'b1, 1'b1, 400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
